// File: rtl/config_uart_word_rx.sv
`default_nettype none
// ============================================================================
// Module   : config_uart_word_rx
// Purpose  : UART receiver front-end for the fabric configuration path.
//            Receives serial bytes, packs four of them big-endian into a
//            32-bit word and presents it as a WriteData/WriteStrobe pair.
//            ComActive marks an active bitstream session and drops after an
//            idle timeout; it feeds the FSM_Reset input of the config FSM.
// Ports    : CLK         - system clock, rising edge
//            resetn      - asynchronous active-low reset
//            Rx          - UART serial input (idle high, asynchronous)
//            WriteData   - last completed 32-bit word
//            WriteStrobe - one-cycle pulse, WriteData valid during it
//            ComActive   - session active flag
//            ErrorFrame  - one-cycle pulse on framing or parity error
// Config   : define CONFIG_UART_PARITY_EN for 8E1 frames (even parity bit
//            between data and stop); undefined gives 8N1.
// Revision : 1.0 - initial release
// ============================================================================
module config_uart_word_rx #(
  parameter int CLK_DIV        = 868,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        CLK,
  input  logic        resetn,
  input  logic        Rx,
  output logic [31:0] WriteData,
  output logic        WriteStrobe,
  output logic        ComActive,
  output logic        ErrorFrame
);

  localparam logic [15:0] c_half_bit = 16'(CLK_DIV / 2);
  localparam logic [15:0] c_full_bit = 16'(CLK_DIV);
  localparam logic [23:0] c_timeout  = 24'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Two-stage synchronizer, idles high so reset does not look like a start bit
  logic        rx_meta_q, rx_s_q;

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_err_q, par_err_d;

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_buf_q, word_buf_d;
  logic [31:0] write_data_q, write_data_d;
  logic        write_strobe_q, write_strobe_d;
  logic        com_active_q, com_active_d;
  logic        error_frame_q, error_frame_d;
  logic [23:0] idle_cnt_q, idle_cnt_d;

  logic        w_tick;
  logic        w_byte_valid;
  logic        w_frame_err;
  logic        w_timeout_hit;

  // Timer is loaded with the interval and counts down; the sample is taken
  // in the cycle it reads 1, giving exactly CLK_DIV/2 then CLK_DIV spacing.
  assign w_tick = (timer_q == 16'd1);

  // ---------------- receiver FSM ----------------
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    par_err_d    = par_err_q;
    w_byte_valid = 1'b0;
    w_frame_err  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          timer_d   = c_half_bit;
          par_err_d = 1'b0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (rx_s_q) begin
            // Start bit vanished by mid-bit: treat as noise, no error
            timer_d = 16'd0;
            state_d = ST_IDLE;
          end else begin
            timer_d   = c_full_bit;
            bit_idx_d = 3'd0;
            state_d   = ST_DATA;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          timer_d   = c_full_bit;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef CONFIG_UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_PARITY: begin
`ifdef CONFIG_UART_PARITY_EN
        if (w_tick) begin
          // Even parity: data ones plus parity bit must be even
          par_err_d = ^{shift_q, rx_s_q};
          timer_d   = c_full_bit;
          state_d   = ST_STOP;
        end else begin
          timer_d = timer_q - 16'd1;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_STOP: begin
        if (w_tick) begin
          if (rx_s_q && !par_err_q) w_byte_valid = 1'b1;
          else                      w_frame_err  = 1'b1;
          timer_d = 16'd0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- word assembly and session control ----------------
  always_comb begin
    idle_cnt_d     = idle_cnt_q;
    byte_cnt_d     = byte_cnt_q;
    word_buf_d     = word_buf_q;
    write_data_d   = write_data_q;
    write_strobe_d = 1'b0;
    error_frame_d  = w_frame_err;

    if (w_byte_valid)                 idle_cnt_d = 24'd0;
    else if (idle_cnt_q != c_timeout) idle_cnt_d = idle_cnt_q + 24'd1;

    // A valid byte in the same cycle always beats the timeout
    w_timeout_hit = !w_byte_valid && (idle_cnt_d == c_timeout);

    if (w_byte_valid)       com_active_d = 1'b1;
    else if (w_timeout_hit) com_active_d = 1'b0;
    else                    com_active_d = com_active_q;

    if (w_byte_valid) begin
      case (byte_cnt_q)
        2'd0: word_buf_d[31:24] = shift_q;
        2'd1: word_buf_d[23:16] = shift_q;
        2'd2: word_buf_d[15:8]  = shift_q;
        default: begin
          write_data_d   = {word_buf_q[31:8], shift_q};
          write_strobe_d = 1'b1;
        end
      endcase
      byte_cnt_d = byte_cnt_q + 2'd1;
    end else if (w_frame_err || w_timeout_hit) begin
      // Drop any partial word so the next byte lands in bits [31:24]
      byte_cnt_d = 2'd0;
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      rx_meta_q      <= 1'b1;
      rx_s_q         <= 1'b1;
      state_q        <= ST_IDLE;
      timer_q        <= 16'd0;
      bit_idx_q      <= 3'd0;
      shift_q        <= 8'd0;
      par_err_q      <= 1'b0;
      byte_cnt_q     <= 2'd0;
      word_buf_q     <= 32'd0;
      write_data_q   <= 32'd0;
      write_strobe_q <= 1'b0;
      com_active_q   <= 1'b0;
      error_frame_q  <= 1'b0;
      idle_cnt_q     <= 24'd0;
    end else begin
      rx_meta_q      <= Rx;
      rx_s_q         <= rx_meta_q;
      state_q        <= state_d;
      timer_q        <= timer_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      par_err_q      <= par_err_d;
      byte_cnt_q     <= byte_cnt_d;
      word_buf_q     <= word_buf_d;
      write_data_q   <= write_data_d;
      write_strobe_q <= write_strobe_d;
      com_active_q   <= com_active_d;
      error_frame_q  <= error_frame_d;
      idle_cnt_q     <= idle_cnt_d;
    end
  end

  assign WriteData   = write_data_q;
  assign WriteStrobe = write_strobe_q;
  assign ComActive   = com_active_q;
  assign ErrorFrame  = error_frame_q;

endmodule
`default_nettype wire

// File: tb/tb_config_uart_word_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_config_uart_word_rx
// Purpose  : Self-checking bench for config_uart_word_rx. Stimulus pushes
//            expected words into a queue; a monitor pops and compares on
//            every WriteStrobe. ErrorFrame pulses are counted and compared.
// Revision : 1.0 - initial release
// ============================================================================
module tb_config_uart_word_rx;

  localparam int DIV = 8;
  localparam int TO  = 100;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rx;
  logic [31:0] write_data;
  logic        write_strobe;
  logic        com_active;
  logic        error_frame;

  int          checks = 0;
  int          errors = 0;
  int          err_seen = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  config_uart_word_rx #(
    .CLK_DIV        (DIV),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK         (clk),
    .resetn      (resetn),
    .Rx          (rx),
    .WriteData   (write_data),
    .WriteStrobe (write_strobe),
    .ComActive   (com_active),
    .ErrorFrame  (error_frame)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: outputs change on posedge, sampled on negedge
  always @(negedge clk) begin
    if (resetn === 1'b1 && write_strobe === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe actual=%h required=none", write_data);
      end else begin
        check("word", write_data, exp_q.pop_front());
      end
    end
    if (resetn === 1'b1 && error_frame === 1'b1) err_seen++;
  end

  task automatic hold_bit(input logic v);
    rx = v;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
`ifdef CONFIG_UART_PARITY_EN
    hold_bit(^b);
`endif
    hold_bit(stop_bit);
    rx = 1'b1;
  endtask

`ifdef CONFIG_UART_PARITY_EN
  task automatic send_bad_parity(input logic [7:0] b);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    hold_bit(~(^b));
    hold_bit(1'b1);
  endtask
`endif

  task automatic send_word(input logic [31:0] w);
    send_frame(w[31:24], 1'b1);
    send_frame(w[23:16], 1'b1);
    send_frame(w[15:8],  1'b1);
    send_frame(w[7:0],   1'b1);
  endtask

  initial begin
    int exp_err;
    exp_err = 0;
    resetn  = 1'b0;
    rx      = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_write_data",   write_data,          32'h0);
    check("rst_write_strobe", {31'd0, write_strobe}, 32'h0);
    check("rst_com_active",   {31'd0, com_active},   32'h0);
    check("rst_error_frame",  {31'd0, error_frame},  32'h0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    // Glitch: 2 cycles low must be rejected silently
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_com_active", {31'd0, com_active}, 32'h0);
    check("glitch_err_count",  err_seen, exp_err);

    // Sync word
    exp_q.push_back(32'hFAB0FAB1);
    send_frame(8'hFA, 1'b1);
    check("sync_com_active_rise", {31'd0, com_active}, 32'h1);
    send_frame(8'hB0, 1'b1);
    send_frame(8'hFA, 1'b1);
    send_frame(8'hB1, 1'b1);
    repeat (4) @(negedge clk);
    check("sync_queue_empty", exp_q.size(), 0);
    check("sync_err_count",   err_seen, exp_err);

    // Framing error drops the partial word
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b0);
    exp_err++;
    repeat (16) @(negedge clk);
    check("frame_err_count", err_seen, exp_err);
    exp_q.push_back(32'hA1B2C3D4);
    send_word(32'hA1B2C3D4);
    repeat (4) @(negedge clk);
    check("frame_queue_empty", exp_q.size(), 0);

    // Timeout: partial word discarded, next session restarts at byte 0
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    send_frame(8'h03, 1'b1);
    check("to_active_after_byte", {31'd0, com_active}, 32'h1);
    repeat (90) @(negedge clk);
    check("to_active_before_limit", {31'd0, com_active}, 32'h1);
    repeat (20) @(negedge clk);
    check("to_inactive_after_limit", {31'd0, com_active}, 32'h0);
    exp_q.push_back(32'h0A0B0C0D);
    send_frame(8'h0A, 1'b1);
    check("to_active_rerise", {31'd0, com_active}, 32'h1);
    send_frame(8'h0B, 1'b1);
    send_frame(8'h0C, 1'b1);
    send_frame(8'h0D, 1'b1);
    repeat (4) @(negedge clk);
    check("to_queue_empty", exp_q.size(), 0);
    check("to_write_data_hold", write_data, 32'h0A0B0C0D);

    // Reset during data bits of byte 2
    send_frame(8'hDE, 1'b1);
    send_frame(8'hAD, 1'b1);
    hold_bit(1'b0);
    hold_bit(1'b0);
    hold_bit(1'b1);
    hold_bit(1'b1);
    resetn = 1'b0;
    rx     = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_write_data",   write_data,            32'h0);
    check("mid_rst_write_strobe", {31'd0, write_strobe}, 32'h0);
    check("mid_rst_com_active",   {31'd0, com_active},   32'h0);
    check("mid_rst_error_frame",  {31'd0, error_frame},  32'h0);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    exp_q.push_back(32'hDEADBEEF);
    send_word(32'hDEADBEEF);
    repeat (4) @(negedge clk);
    check("rst_queue_empty", exp_q.size(), 0);
    check("rst_write_data_hold", write_data, 32'hDEADBEEF);

`ifdef CONFIG_UART_PARITY_EN
    // 0x03 has two ones: parity 1 is wrong, parity 0 is right
    send_bad_parity(8'h03);
    exp_err++;
    repeat (4) @(negedge clk);
    check("par_err_count", err_seen, exp_err);
    exp_q.push_back(32'h03040506);
    send_word(32'h03040506);
    repeat (4) @(negedge clk);
    check("par_queue_empty", exp_q.size(), 0);
`endif

    repeat (10) @(negedge clk);
    check("final_err_count", err_seen, exp_err);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
